tile_map_arbiter: RTL and testbench

Arbiter and fetch sequencer for the single-port tile-map RAM behind the map renderer. Every 16 pixels it steals one memory cycle to prefetch the next 16x16 tile index for the 640x480 raster, driven by the hvsync_gen position counters. All other cycles go round-robin to a game-logic write port and a game-logic read port (collision lookups), each using a valid/ready handshake. It sits between hvsync_gen and map_rgb and owns the RAM port outright.

---
 rtl/tile_map_if.sv | 19 +
 rtl/tile_map_arbiter.sv | 59 +++++
 tb/tb_tile_map_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/tile_map_if.sv
// tile_map_if: raster position, game-logic read/write handshakes and tile-map RAM port
interface tile_map_if #(
  parameter int TILE_BITS = 8,
  parameter int ADDR_BITS = 11
);
  logic [9:0] hpos, vpos;
  logic wr_valid, wr_ready, rd_valid, rd_ready, rd_data_valid;
  logic [ADDR_BITS-1:0] wr_addr, rd_addr, mem_addr;
  logic [TILE_BITS-1:0] wr_data, rd_data, mem_wdata, mem_rdata, tile;
  logic mem_en, mem_we;
  modport master (
    output hpos, vpos, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
    input  wr_ready, rd_ready, rd_data, rd_data_valid, mem_en, mem_we, mem_addr, mem_wdata, tile
  );
  modport slave (
    input  hpos, vpos, wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
    output wr_ready, rd_ready, rd_data, rd_data_valid, mem_en, mem_we, mem_addr, mem_wdata, tile
  );
endinterface

// File: rtl/tile_map_arbiter.sv
// tile_map_arbiter: tile-map RAM owner; raster tile prefetch preempts round-robin write/read ports
module tile_map_arbiter #(
  parameter int TILE_BITS = 8,
  parameter int ADDR_BITS = 11,
  parameter bit WRITE_VBLANK_ONLY = 1'b1
) (
  input logic clk,
  input logic rst,
  tile_map_if.slave bus
);
  typedef enum logic [1:0] {NONE, FETCH, READ} tag_t;
  tag_t tag, tag_nxt;
  logic [9:0] nxt_line;
  logic in_slot, ls_slot, fetch, wr_elig, rd_elig, wr_gnt, rd_gnt, rr, load;
  logic [4:0] f_row;
  logic [5:0] f_col;
  logic [ADDR_BITS-1:0] f_addr;
  logic [TILE_BITS-1:0] next_q, rd_hold, tile_q;
  always_comb begin
    nxt_line = (bus.vpos == 10'd524) ? 10'd0 : bus.vpos + 10'd1;
    in_slot = bus.vpos < 10'd480 && bus.hpos < 10'd624 && bus.hpos[3:0] == 4'd0;
    ls_slot = bus.hpos == 10'd784 && nxt_line < 10'd480;
    fetch = !rst && (in_slot || ls_slot);
    f_row = in_slot ? bus.vpos[8:4] : nxt_line[8:4];
    f_col = in_slot ? bus.hpos[9:4] + 6'd1 : 6'd0;
    f_addr = (ADDR_BITS'(f_row) << 5) + (ADDR_BITS'(f_row) << 3) + ADDR_BITS'(f_col);
    wr_elig = bus.wr_valid && (!WRITE_VBLANK_ONLY || bus.vpos >= 10'd480);
    rd_elig = bus.rd_valid;
    wr_gnt = !rst && !fetch && wr_elig && (!rd_elig || !rr);
    rd_gnt = !rst && !fetch && rd_elig && (!wr_elig || rr);
    tag_nxt = fetch ? FETCH : rd_gnt ? READ : NONE;
    load = (bus.hpos[3:0] == 4'd15 && bus.hpos < 10'd624) || bus.hpos == 10'd799;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tag <= NONE;
      rr <= 1'b0;
      next_q <= '0;
      rd_hold <= '0;
      tile_q <= '0;
    end else begin
      tag <= tag_nxt;
      if (wr_gnt || rd_gnt) rr <= !rr;
      if (tag == FETCH) next_q <= bus.mem_rdata;
      if (tag == READ) rd_hold <= bus.mem_rdata;
      if (load) tile_q <= next_q;
    end
  end
  assign bus.wr_ready = wr_gnt;
  assign bus.rd_ready = rd_gnt;
  assign bus.mem_en = fetch || wr_gnt || rd_gnt;
  assign bus.mem_we = wr_gnt;
  assign bus.mem_addr = fetch ? f_addr : wr_gnt ? bus.wr_addr : rd_gnt ? bus.rd_addr : '0;
  assign bus.mem_wdata = wr_gnt ? bus.wr_data : '0;
  // Read data is the RAM output passed straight through on return, then held.
  assign bus.rd_data_valid = !rst && tag == READ;
  assign bus.rd_data = rst ? '0 : (tag == READ) ? bus.mem_rdata : rd_hold;
  assign bus.tile = tile_q;
endmodule

// File: tb/tb_tile_map_arbiter.sv
// tb_tile_map_arbiter: directed checks of raster prefetch, preemption, round-robin and write lock
module tb_tile_map_arbiter;
  logic clk = 1'b0, rst;
  logic [9:0] hpos, vpos;
  logic wr_valid, rd_valid;
  logic [10:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [7:0] mem [0:2047];
  logic [7:0] e;
  int checks = 0, fails = 0;

  tile_map_if #(.TILE_BITS(8), .ADDR_BITS(11)) bus ();
  tile_map_if #(.TILE_BITS(8), .ADDR_BITS(11)) bus0 ();

  tile_map_arbiter #(.TILE_BITS(8), .ADDR_BITS(11), .WRITE_VBLANK_ONLY(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  tile_map_arbiter #(.TILE_BITS(8), .ADDR_BITS(11), .WRITE_VBLANK_ONLY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  always #5 clk = ~clk;

  assign bus.hpos = hpos;
  assign bus.vpos = vpos;
  assign bus.wr_valid = wr_valid;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_addr = rd_addr;
  assign bus0.hpos = hpos;
  assign bus0.vpos = vpos;
  assign bus0.wr_valid = wr_valid;
  assign bus0.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;
  assign bus0.rd_valid = 1'b0;
  assign bus0.rd_addr = '0;
  assign bus0.mem_rdata = '0;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (hpos == 10'd799) begin
      hpos = 10'd0;
      vpos = (vpos == 10'd524) ? 10'd0 : vpos + 10'd1;
    end else hpos = hpos + 10'd1;
  endtask

  task automatic go(input logic [9:0] h, input logic [9:0] v);
    @(posedge clk);
    #1;
    hpos = h;
    vpos = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2048; k++) mem[k] = 8'(k);
    mem[1199] = 8'hA5;
    rst = 1'b1;
    hpos = 10'd0;
    vpos = 10'd500;
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    wr_addr = 11'd1500;
    wr_data = 8'h33;
    rd_addr = 11'd1199;
    repeat (2) begin
      @(negedge clk);
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_rd_ready", bus.rd_ready, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_rd_valid", bus.rd_data_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_tile", bus.tile, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_wr_ready", bus.wr_ready, (i % 2 == 0) ? 1 : 0);
      chk("rr_rd_ready", bus.rd_ready, (i % 2 == 1) ? 1 : 0);
      chk("rr_rd_valid", bus.rd_data_valid, (i == 2) ? 1 : 0);
      if (i == 0) begin
        chk("wr_mem_we", bus.mem_we, 1);
        chk("wr_mem_addr", bus.mem_addr, 1500);
        chk("wr_mem_wdata", bus.mem_wdata, 8'h33);
      end
      if (i == 1) chk("rd_mem_addr", bus.mem_addr, 1199);
      if (i == 2) chk("rr_rd_data", bus.rd_data, 8'hA5);
      adv();
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    @(negedge clk);
    chk("ret_rd_valid", bus.rd_data_valid, 1);
    chk("ret_rd_data", bus.rd_data, 8'hA5);
    chk("ret_tile", bus.tile, 0);
    adv();
    @(negedge clk);
    chk("ret_pulse_end", bus.rd_data_valid, 0);
    chk("ret_hold", bus.rd_data, 8'hA5);
    rd_valid = 1'b1;
    @(negedge clk);
    chk("mid_rd_ready", bus.rd_ready, 1);
    adv();
    rst = 1'b1;
    rd_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_no_valid", bus.rd_data_valid, 0);
    adv();
    rst = 1'b0;
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    @(negedge clk);
    chk("rr_after_rst_wr", bus.wr_ready, 1);
    chk("rr_after_rst_rd", bus.rd_ready, 0);
    adv();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    hpos = 10'd780;
    vpos = 10'd524;
    while (hpos != 10'd784) adv();
    @(negedge clk);
    chk("ls_524_en", bus.mem_en, 1);
    chk("ls_524_we", bus.mem_we, 0);
    chk("ls_524_addr", bus.mem_addr, 0);
    while (!(vpos == 10'd0 && hpos == 10'd0)) adv();
    for (int j = 0; j < 640; j++) begin
      @(negedge clk);
      e = (hpos >= 10'd624) ? 8'd39 : 8'(hpos >> 4);
      if (hpos[3:0] == 4'd0 || hpos[3:0] == 4'd15) chk("line0_tile", bus.tile, e);
      adv();
    end
    go(10'd780, 10'd15);
    while (!(vpos == 10'd16 && hpos == 10'd0)) adv();
    @(negedge clk);
    chk("line16_tile0", bus.tile, 40);
    while (hpos != 10'd16) adv();
    @(negedge clk);
    chk("line16_tile1", bus.tile, 41);
    go(10'd600, 10'd479);
    while (hpos != 10'd608) adv();
    @(negedge clk);
    chk("last_fetch_en", bus.mem_en, 1);
    chk("last_fetch_addr", bus.mem_addr, 1199);
    while (hpos != 10'd624) adv();
    @(negedge clk);
    chk("last_tile", bus.tile, 8'hA5);
    chk("no_fetch_624", bus.mem_en, 0);
    while (hpos != 10'd784) adv();
    @(negedge clk);
    chk("ls_479_free", bus.mem_en, 0);
    go(10'd16, 10'd5);
    wr_valid = 1'b1;
    wr_addr = 11'd77;
    wr_data = 8'h5C;
    @(negedge clk);
    chk("pre_wr_ready16", bus0.wr_ready, 0);
    chk("pre_fetch_addr", bus0.mem_addr, 2);
    chk("pre_fetch_we", bus0.mem_we, 0);
    chk("lock_wr_ready16", bus.wr_ready, 0);
    adv();
    @(negedge clk);
    chk("pre_wr_ready17", bus0.wr_ready, 1);
    chk("pre_mem_we", bus0.mem_we, 1);
    chk("pre_mem_addr", bus0.mem_addr, 77);
    chk("pre_mem_wdata", bus0.mem_wdata, 8'h5C);
    chk("lock_wr_ready17", bus.wr_ready, 0);
    go(10'd0, 10'd100);
    wr_addr = 11'd10;
    wr_data = 8'h11;
    for (int j = 0; j < 8; j++) begin
      rd_valid = hpos[0];
      #1;
      @(negedge clk);
      chk("lock_wr", bus.wr_ready, 0);
      chk("lock_rd", bus.rd_ready, {31'd0, hpos[0]});
      adv();
    end
    rd_valid = 1'b0;
    go(10'd798, 10'd479);
    @(negedge clk);
    chk("lock_798", bus.wr_ready, 0);
    adv();
    @(negedge clk);
    chk("lock_799", bus.wr_ready, 0);
    adv();
    @(negedge clk);
    chk("unlock_ready", bus.wr_ready, 1);
    chk("unlock_we", bus.mem_we, 1);
    chk("unlock_addr", bus.mem_addr, 10);
    chk("unlock_wdata", bus.mem_wdata, 8'h11);
    adv();
    wr_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
